// File: rtl/pulse_to_edge.sv
// Converts single-cycle event pulses into spaced HIGH windows on level_out.
// Events arriving while a window or gap is in progress are counted and replayed later.
module pulse_to_edge #(
   parameter int unsigned HIGH_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 4,
   parameter int unsigned PEND_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pulse_in,
   input  logic              clear,
   output logic              level_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int unsigned MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
   localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

   localparam logic [TMR_W-1:0]  HIGH_LOAD = TMR_W'(HIGH_CYCLES - 1);
   localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t            r_state;
   logic [TMR_W-1:0]  r_timer;
   logic [PEND_W-1:0] r_pending;
   logic              r_overflow;
   logic              r_level;
   logic              r_busy;

   logic w_tmr_done;
   logic w_has_pend;
   logic w_sat;

   assign w_tmr_done = (r_timer == '0);
   assign w_has_pend = (r_pending != '0);
   assign w_sat      = (r_pending == PEND_MAX);

   // State, timer, event queue and outputs all advance together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_timer    <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
         r_level    <= 1'b0;
         r_busy     <= 1'b0;
      end else if (clear) begin
         r_state    <= ST_IDLE;
         r_timer    <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
         r_level    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (pulse_in) begin
                  r_state <= ST_HIGH;
                  r_timer <= HIGH_LOAD;
                  r_level <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end

            ST_HIGH: begin
               if (pulse_in) begin
                  if (w_sat) r_overflow <= 1'b1;
                  else       r_pending  <= r_pending + PEND_W'(1);
               end
               if (w_tmr_done) begin
                  r_state <= ST_GAP;
                  r_timer <= GAP_LOAD;
                  r_level <= 1'b0;
               end else begin
                  r_timer <= r_timer - TMR_W'(1);
               end
            end

            ST_GAP: begin
               if (w_tmr_done) begin
                  // A queued event is replayed first; a fresh pulse here replaces the dequeue.
                  if (w_has_pend || pulse_in) begin
                     r_state <= ST_HIGH;
                     r_timer <= HIGH_LOAD;
                     r_level <= 1'b1;
                     if (w_has_pend && !pulse_in) r_pending <= r_pending - PEND_W'(1);
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_timer <= r_timer - TMR_W'(1);
                  if (pulse_in) begin
                     if (w_sat) r_overflow <= 1'b1;
                     else       r_pending  <= r_pending + PEND_W'(1);
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_timer <= '0;
               r_level <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign level_out = r_level;
   assign busy      = r_busy;
   assign pending   = r_pending;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_pulse_to_edge.sv
// Scoreboard bench for pulse_to_edge: default instance and a PEND_W=2 instance
// share stimulus and are checked against an event-period reference model.
module tb_pulse_to_edge;

   localparam int H      = 4;
   localparam int G      = 4;
   localparam int PMAX_D = 15;
   localparam int PMAX_S = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pulse_in = 1'b0;
   logic       clear = 1'b0;
   logic       level_d, busy_d, ovf_d;
   logic [3:0] pend_d;
   logic       level_s, busy_s, ovf_s;
   logic [1:0] pend_s;

   int checks = 0;
   int failures = 0;

   pulse_to_edge #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear),
      .level_out(level_d), .busy(busy_d), .pending(pend_d), .overflow(ovf_d));

   pulse_to_edge #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear),
      .level_out(level_s), .busy(busy_s), .pending(pend_s), .overflow(ovf_s));

   always #5 clk = ~clk;

   // Reference: phase = cycle index within the current H+G event period, -1 when idle.
   typedef struct {
      int phase;
      int queued;
      bit ovf;
   } mdl_t;

   mdl_t m_d = '{phase: -1, queued: 0, ovf: 1'b0};
   mdl_t m_s = '{phase: -1, queued: 0, ovf: 1'b0};

   logic [6:0] exp_q  [$];
   logic [6:0] exp_qs [$];

   function automatic mdl_t step(input mdl_t m, input bit p, input bit c, input int pmax);
      mdl_t n = m;
      if (c) begin
         n.phase = -1; n.queued = 0; n.ovf = 1'b0;
      end else if (m.phase < 0) begin
         if (p) n.phase = 0;
      end else if (m.phase == H + G - 1) begin
         if (m.queued > 0) begin
            n.phase = 0;
            n.queued = m.queued - 1 + (p ? 1 : 0);
         end else if (p) begin
            n.phase = 0;
         end else begin
            n.phase = -1;
         end
      end else begin
         n.phase = m.phase + 1;
         if (p) begin
            if (m.queued == pmax) n.ovf = 1'b1;
            else                  n.queued = m.queued + 1;
         end
      end
      return n;
   endfunction

   function automatic logic [6:0] outs(input mdl_t m);
      logic lvl = (m.phase >= 0) && (m.phase < H);
      logic bsy = (m.phase >= 0);
      return {lvl, bsy, 4'(m.queued), m.ovf};
   endfunction

   // Model advances on each active edge and queues the outputs expected after it.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_d = '{phase: -1, queued: 0, ovf: 1'b0};
         m_s = '{phase: -1, queued: 0, ovf: 1'b0};
      end else begin
         m_d = step(m_d, pulse_in, clear, PMAX_D);
         m_s = step(m_s, pulse_in, clear, PMAX_S);
      end
      exp_q.push_back(outs(m_d));
      exp_qs.push_back(outs(m_s));
   end

   // Monitor: compare presented outputs mid-cycle against the queued expectation.
   always @(negedge clk) begin
      logic [6:0] e;
      logic [6:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (!rst_n) e = '0;
         a = {level_d, busy_d, pend_d, ovf_d};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL dflt_out t=%0t got{lvl,busy,pend,ovf}=%b required=%b", $time, a, e);
         end
      end
      if (exp_qs.size() > 0) begin
         e = exp_qs.pop_front();
         if (!rst_n) e = '0;
         a = {level_s, busy_s, 4'(pend_s), ovf_s};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL sat_out t=%0t got{lvl,busy,pend,ovf}=%b required=%b", $time, a, e);
         end
      end
   end

   task automatic cyc(input bit p, input bit c);
      @(posedge clk);
      #2;
      pulse_in = p;
      clear = c;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
   endtask

   // Assert reset between edges and confirm outputs drop without waiting for a clock.
   task automatic async_reset(input int hold);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      pulse_in = 1'b0;
      clear = 1'b0;
      #1;
      checks++;
      if ({level_d, busy_d, pend_d, ovf_d, level_s, busy_s, pend_s, ovf_s} !== '0) begin
         failures++;
         $display("FAIL async_reset got=%b%b%b%b %b%b%b%b required=all zero",
                  level_d, busy_d, pend_d, ovf_d, level_s, busy_s, pend_s, ovf_s);
      end
      for (int i = 0; i < hold; i++) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      idle(3);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      cyc(1, 0); idle(12);                          // single event
      cyc(1, 0); cyc(1, 0); cyc(1, 0); idle(30);    // three back-to-back events
      for (int i = 0; i < 6; i++) cyc(1, 0);        // saturate the narrow counter
      idle(40);
      cyc(0, 1); idle(2);
      cyc(1, 0); idle(7); cyc(1, 0); idle(20);      // event on the final gap cycle
      cyc(1, 0); cyc(1, 0); cyc(1, 1); idle(12);    // clear with a coincident pulse
      cyc(1, 0); idle(3); async_reset(2);           // reset mid high window
      cyc(1, 0); idle(12);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            async_reset($urandom_range(1, 3));
         end else begin
            cyc($urandom_range(0, 99) < 35, $urandom_range(0, 199) < 2);
         end
      end
      idle(60);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
